// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MIPS MEM stage.
// Single-outstanding request/ack memory port; line refill and victim write-back are sequenced by a 3-state FSM.
module dcache_controller #(
   parameter int unsigned LINES     = 32,
   parameter int unsigned LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   input  logic [31:0]          p1_addr_i,
   input  logic [31:0]          p1_data_i,
   output logic [31:0]          p1_data_o,
   output logic                 p1_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
   localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
   localparam int unsigned WSEL_W = OFF_W - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITEBACK,
      S_ALLOCATE
   } state_t;

   state_t               r_state;
   logic [LINES-1:0]     r_valid;
   logic [LINES-1:0]     r_dirty;
   logic [TAG_W-1:0]     r_tag  [LINES];
   logic [LINE_BITS-1:0] r_data [LINES];

   logic [TAG_W-1:0]     w_tag;
   logic [IDX_W-1:0]     w_idx;
   logic [WSEL_W-1:0]    w_wsel;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_store_hit;
   logic [LINE_BITS-1:0] w_line;
   logic [31:0]          w_word;
   logic                 w_unused_addr;

   assign w_tag         = p1_addr_i[31 -: TAG_W];
   assign w_idx         = p1_addr_i[OFF_W +: IDX_W];
   assign w_wsel        = p1_addr_i[2 +: WSEL_W];
   assign w_unused_addr = ^p1_addr_i[1:0];
   assign w_req         = p1_MemRead_i | p1_MemWrite_i;
   assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_store_hit   = (r_state == S_IDLE) && p1_MemWrite_i && w_hit;
   assign w_line        = r_data[w_idx];
   assign w_word        = w_line[{w_wsel, 5'b0} +: 32];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_hit) begin
                     if (p1_MemWrite_i) r_dirty[w_idx] <= 1'b1;
                  end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state <= S_WRITEBACK;
                  end else begin
                     r_state <= S_ALLOCATE;
                  end
               end
            end
            S_WRITEBACK: begin
               if (mem_ack_i) r_state <= S_ALLOCATE;
            end
            S_ALLOCATE: begin
               if (mem_ack_i) begin
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and line storage carry no reset; validity alone gates their use.
   always_ff @(posedge clk_i) begin
      if (w_store_hit) begin
         r_data[w_idx][{w_wsel, 5'b0} +: 32] <= p1_data_i;
      end else if ((r_state == S_ALLOCATE) && mem_ack_i) begin
         r_data[w_idx] <= mem_data_i;
         r_tag[w_idx]  <= w_tag;
      end
   end

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (r_state)
         S_WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
            mem_data_o   = r_data[w_idx];
         end
         S_ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {p1_addr_i[31:OFF_W], {OFF_W{1'b0}}};
         end
         default: ;
      endcase
   end

   // Stall is forced low while reset is held even if the CPU keeps its request up.
   assign p1_stall_o = rst_i && ((r_state != S_IDLE) || (w_req && !w_hit));
   assign p1_data_o  = ((r_state == S_IDLE) && w_hit && p1_MemRead_i) ? w_word : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: golden word-memory model, behavioural latency-programmable memory,
// queues of expected memory transactions and load results.
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         p1_MemRead_i = 1'b0;
   logic         p1_MemWrite_i = 1'b0;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;

   always #5 clk_i = ~clk_i;

   dcache_controller #(.LINES(32), .LINE_BITS(256)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   int unsigned checks = 0;
   int unsigned failures = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
   } tx_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned lat;
      logic        miss;
      logic        wb;
      logic [31:0] wb_addr;
   } vec_t;

   tx_t         tx_q[$];
   logic [31:0] ld_q[$];
   logic [31:0] gold [logic [31:0]];
   logic [31:0] memw [logic [31:0]];
   int unsigned mem_lat = 1;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5C3_0000 ^ {a[18:0], 13'h0};
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return gold.exists(k) ? gold[k] : pat(k);
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_rd({a[31:5], 3'(w), 2'b00});
      return l;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      logic [255:0] l;
      logic [31:0]  k;
      for (int w = 0; w < 8; w++) begin
         k = {a[31:5], 3'(w), 2'b00};
         l[32*w +: 32] = memw.exists(k) ? memw[k] : pat(k);
      end
      return l;
   endfunction

   // Behavioural memory: ack in the mem_lat-th cycle of each request.
   initial begin : memory_model
      int unsigned cnt;
      tx_t         cur;
      logic        have;
      cnt  = 0;
      have = 1'b0;
      cur  = '{1'b0, 32'h0};
      forever begin
         @(posedge clk_i);
         #1;
         mem_ack_i  = 1'b0;
         mem_data_i = {8{$urandom()}};
         if (!mem_enable_o) begin
            cnt = 0;
         end else begin
            if (cnt == 0) begin
               if (tx_q.size() == 0) begin
                  chk32("tx_unexpected_addr", mem_addr_o, 32'hFFFF_FFFF);
                  have = 1'b0;
               end else begin
                  cur  = tx_q.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               chk32("tx_write", 32'(mem_write_o), 32'(cur.we));
               chk32("tx_addr", mem_addr_o, cur.addr);
               if (cur.we) chk256("tx_wb_line", mem_data_o, gold_line(cur.addr));
            end
            cnt++;
            if (cnt >= mem_lat) begin
               mem_ack_i = 1'b1;
               if (mem_write_o) begin
                  for (int w = 0; w < 8; w++)
                     memw[{mem_addr_o[31:5], 3'(w), 2'b00}] = mem_data_o[32*w +: 32];
               end else begin
                  mem_data_i = mem_line(mem_addr_o);
               end
               cnt = 0;
            end
         end
      end
   end

   function automatic vec_t mkv(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input int unsigned lat,
                                input logic miss, input logic wb, input logic [31:0] wb_addr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.lat = lat; v.miss = miss; v.wb = wb; v.wb_addr = wb_addr;
      return v;
   endfunction

   // Called at posedge+1; returns at the following posedge+1 with the request dropped.
   task automatic do_access(input string tag, input vec_t v);
      int unsigned stalls;
      int unsigned exp_stall;
      mem_lat = v.lat;
      if (v.miss) begin
         if (v.wb) tx_q.push_back('{1'b1, v.wb_addr});
         tx_q.push_back('{1'b0, {v.addr[31:5], 5'b0}});
      end
      exp_stall = !v.miss ? 0 : (v.wb ? 2 * v.lat + 1 : v.lat + 1);
      if (v.wr) gold[{v.addr[31:2], 2'b00}] = v.wdata;
      else if (v.rd) ld_q.push_back(gold_rd(v.addr));
      p1_MemRead_i  = v.rd;
      p1_MemWrite_i = v.wr;
      p1_addr_i     = v.addr;
      p1_data_i     = v.wdata;
      @(negedge clk_i);
      stalls = 0;
      while (p1_stall_o === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk_i);
      end
      chk32({tag, "_stall_cycles"}, stalls, exp_stall);
      chk32({tag, "_mem_enable_idle"}, 32'(mem_enable_o), 32'h0);
      if (v.rd && !v.wr) chk32({tag, "_load_data"}, p1_data_o, ld_q.pop_front());
      else if (!v.rd && !v.wr) chk32({tag, "_idle_data"}, p1_data_o, 32'h0);
      @(posedge clk_i);
      #1;
      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vtab[19];
      vtab[0]  = mkv(1, 0, 32'h0000_0040, 32'h0,         10, 1, 0, 32'h0);
      vtab[1]  = mkv(1, 0, 32'h0000_0044, 32'h0,          1, 0, 0, 32'h0);
      vtab[2]  = mkv(1, 0, 32'h0000_005C, 32'h0,          1, 0, 0, 32'h0);
      vtab[3]  = mkv(0, 1, 32'h0000_0048, 32'hDEAD_BEEF,  1, 0, 0, 32'h0);
      vtab[4]  = mkv(1, 0, 32'h0000_0048, 32'h0,          1, 0, 0, 32'h0);
      vtab[5]  = mkv(1, 0, 32'h0000_0440, 32'h0,          4, 1, 1, 32'h0000_0040);
      vtab[6]  = mkv(0, 1, 32'h0000_0084, 32'h1234_5678,  2, 1, 0, 32'h0);
      vtab[7]  = mkv(1, 0, 32'h0000_0084, 32'h0,          1, 0, 0, 32'h0);
      vtab[8]  = mkv(1, 0, 32'h0000_0484, 32'h0,          3, 1, 1, 32'h0000_0080);
      vtab[9]  = mkv(1, 0, 32'h0000_0048, 32'h0,          1, 1, 0, 32'h0);
      vtab[10] = mkv(1, 1, 32'h0000_004C, 32'hCAFE_F00D,  1, 0, 0, 32'h0);
      vtab[11] = mkv(1, 0, 32'h0000_004F, 32'h0,          1, 0, 0, 32'h0);
      vtab[12] = mkv(0, 0, 32'h0000_0040, 32'h0,          1, 0, 0, 32'h0);
      vtab[13] = mkv(1, 0, 32'h0000_03E0, 32'h0,          5, 1, 0, 32'h0);
      vtab[14] = mkv(1, 0, 32'h0000_03FC, 32'h0,          1, 0, 0, 32'h0);
      vtab[15] = mkv(0, 1, 32'hFFFF_FFFC, 32'h0BAD_F00D,  2, 1, 0, 32'h0);
      vtab[16] = mkv(1, 0, 32'hFFFF_FFE0, 32'h0,          1, 0, 0, 32'h0);
      vtab[17] = mkv(1, 0, 32'h0000_03E4, 32'h0,          2, 1, 1, 32'hFFFF_FFE0);
      vtab[18] = mkv(1, 0, 32'h0000_0440, 32'h0,          1, 1, 1, 32'h0000_0040);

      #3;
      chk32("reset_stall", 32'(p1_stall_o), 32'h0);
      chk32("reset_mem_enable", 32'(mem_enable_o), 32'h0);
      chk32("reset_mem_write", 32'(mem_write_o), 32'h0);
      chk32("reset_mem_addr", mem_addr_o, 32'h0);
      chk256("reset_mem_data", mem_data_o, 256'h0);
      chk32("reset_load_data", p1_data_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 19; i++) do_access($sformatf("vec%0d", i), vtab[i]);

      // Reset asserted during the 3rd ALLOCATE cycle of a load miss.
      mem_lat = 20;
      tx_q.push_back('{1'b0, 32'h0000_00C0});
      p1_MemRead_i = 1'b1;
      p1_addr_i    = 32'h0000_00C0;
      repeat (3) @(posedge clk_i);
      #1;
      chk32("alloc3_mem_enable", 32'(mem_enable_o), 32'h1);
      #1;
      rst_i = 1'b0;
      #1;
      chk32("midrst_mem_enable", 32'(mem_enable_o), 32'h0);
      chk32("midrst_stall", 32'(p1_stall_o), 32'h0);
      chk32("midrst_mem_addr", mem_addr_o, 32'h0);
      p1_MemRead_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      do_access("post_rst_miss", mkv(1, 0, 32'h0000_0044, 32'h0, 3, 1, 0, 32'h0));
      do_access("post_rst_hit",  mkv(1, 0, 32'h0000_004C, 32'h0, 1, 0, 0, 32'h0));

      chk32("tx_queue_drained", tx_q.size(), 32'h0);
      chk32("load_queue_drained", ld_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
